// File: rtl/cpu_pkg.sv
// cpu_pkg
//  Shared definitions for the 5-stage pipelined CPU front end.
//  - ADDR_W / DATA_W : program counter and data word widths
//  - PSR_*           : bit positions of the condition flags in program_status
//  - opcode / branch-condition codes consumed by decode and execute
//  - psr_calc        : flag generator shared by the RTL
package cpu_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  // program_status bit indices, packed as {C,P,Z,N,PAR}
  localparam int PSR_C   = 4;
  localparam int PSR_P   = 3;
  localparam int PSR_Z   = 2;
  localparam int PSR_N   = 1;
  localparam int PSR_PAR = 0;

  // Opcodes
  localparam logic [3:0] LOAD   = 4'h0;
  localparam logic [3:0] STORE  = 4'h1;
  localparam logic [3:0] ADD    = 4'h2;
  localparam logic [3:0] SUB    = 4'h3;
  localparam logic [3:0] AND_OP = 4'h4;
  localparam logic [3:0] OR_OP  = 4'h5;
  localparam logic [3:0] XOR_OP = 4'h6;
  localparam logic [3:0] SHL    = 4'h7;
  localparam logic [3:0] SHR    = 4'h8;
  localparam logic [3:0] BRANCH = 4'h9;
  localparam logic [3:0] NOOP   = 4'hF;

  // Branch condition codes and the flag each one tests
  typedef enum logic [2:0] {
    BR_ALWAYS   = 3'd0,  // unconditional
    BR_NOT_ZERO = 3'd1,  // Z == 0
    BR_ZERO     = 3'd2,  // Z == 1
    BR_POSITIVE = 3'd3,  // P == 1
    BR_NO_CARRY = 3'd4,  // C == 0
    BR_PAR_EVEN = 3'd5,  // PAR == 0
    BR_PAR_ODD  = 3'd6   // PAR == 1
  } br_cond_e;

  // Condition flags from a result word and its carry.
  function automatic logic [4:0] psr_calc(input logic [DATA_W-1:0] res,
                                          input logic carry);
    logic [4:0] flags;
    logic       is_zero;
    is_zero        = (res == '0);
    flags          = '0;
    flags[PSR_C]   = carry;
    flags[PSR_Z]   = is_zero;
    flags[PSR_N]   = res[DATA_W-1];
    // positive excludes both zero and the sign-set case, so P/Z/N stay one-hot
    flags[PSR_P]   = ~res[DATA_W-1] & ~is_zero;
    flags[PSR_PAR] = ^res;
    return flags;
  endfunction

endpackage

// File: rtl/pc_psr_unit_if.sv
// pc_psr_unit_if
//  Bundle between the pipeline and the PC/PSR front-end block.
//  master (pipeline side): drives branch request and write-back result,
//                          reads fetch address and flags.
//  slave  (pc_psr_unit)  : the reverse.
//   branch_valid    1       load branch_address into PC on next edge
//   branch_address  ADDR_W  branch target (instruction word address)
//   res             DATA_W  write-back result word
//   carry           1       write-back carry
//   cnt             ADDR_W  current PC / instruction read address
//   program_status  5       {C,P,Z,N,PAR}
interface pc_psr_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic              branch_valid;
  logic [ADDR_W-1:0] branch_address;
  logic [DATA_W-1:0] res;
  logic              carry;
  logic [ADDR_W-1:0] cnt;
  logic [4:0]        program_status;

  modport master (
    output branch_valid, branch_address, res, carry,
    input  cnt, program_status
  );

  modport slave (
    input  branch_valid, branch_address, res, carry,
    output cnt, program_status
  );

endinterface

// File: rtl/psr_flags.sv
// psr_flags
//  Purely combinational condition-flag generator. No clock, no reset.
//   res             in   DATA_W  write-back result word
//   carry           in   1       write-back carry
//   program_status  out  5       {C,P,Z,N,PAR}
module psr_flags
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] res,
  input  logic              carry,
  output logic [4:0]        program_status
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (res == '0);
  assign is_neg  = res[DATA_W-1];

  assign program_status[PSR_C]   = carry;
  assign program_status[PSR_P]   = ~is_neg & ~is_zero;
  assign program_status[PSR_Z]   = is_zero;
  assign program_status[PSR_N]   = is_neg;
  assign program_status[PSR_PAR] = ^res;

endmodule

// File: rtl/pc_psr_unit.sv
// pc_psr_unit
//  Front-end control: program counter plus program status flags.
//  The PC advances every cycle (no stall), or loads the branch target
//  when execute resolves a taken branch. Flags are combinational from
//  the write-back result and do not see reset.
//   clk     in  1   rising-edge clock
//   resetn  in  1   asynchronous reset, active HIGH despite the name
//   bus     slave   pc_psr_unit_if (branch request, result, cnt, flags)
module pc_psr_unit
  import cpu_pkg::*;
#(
  parameter int                       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                       DATA_W   = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic        clk,
  input  logic        resetn,
  pc_psr_unit_if.slave bus
);

  logic [ADDR_W-1:0] cnt_reg;
  logic [ADDR_W-1:0] cnt_next;

  // Branch has priority; otherwise increment, wrapping naturally at 2**ADDR_W.
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (bus.branch_valid) begin
      cnt_next = bus.branch_address;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt_reg <= RESET_PC;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bus.cnt = cnt_reg;

  psr_flags #(
    .DATA_W (DATA_W)
  ) u_psr_flags (
    .res            (bus.res),
    .carry          (bus.carry),
    .program_status (bus.program_status)
  );

endmodule

// File: tb/tb_pc_psr_unit.sv
module tb_pc_psr_unit;

  logic clk;
  logic resetn;
  int   pass_cnt;
  int   total_cnt;

  pc_psr_unit_if bus ();

  pc_psr_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      pass_cnt++;
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Independent flag reference: {C,P,Z,N,PAR}
  function automatic logic [4:0] ref_flags(input logic [31:0] r, input logic c);
    logic z, n, p, par;
    int   ones;
    ones = 0;
    for (int b = 0; b < 32; b++) ones += int'(r[b]);
    z   = (r == 32'd0);
    n   = r[31];
    p   = !n && !z;
    par = ones[0];
    return {c, p, z, n, par};
  endfunction

  typedef struct {
    logic [31:0] res;
    logic        carry;
    logic [4:0]  exp;
    string       tag;
  } psr_vec_t;

  psr_vec_t psr_vecs[5];

  initial begin
    logic [10:0] exp_pc;
    logic [4:0]  f;
    pass_cnt  = 0;
    total_cnt = 0;
    resetn             = 1'b1;
    bus.branch_valid   = 1'b0;
    bus.branch_address = '0;
    bus.res            = '0;
    bus.carry          = 1'b0;

    // 1: reset behaviour
    repeat (2) @(negedge clk);
    check("reset_state", 32'(bus.cnt), 32'd0);
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    check("count_to_5", 32'(bus.cnt), 32'd5);
    #2 resetn = 1'b1;
    #1 check("async_reset", 32'(bus.cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", 32'(bus.cnt), 32'd0);
    end

    // 2: sequential count after release, then wrap
    resetn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("seq_count", 32'(bus.cnt), 32'(i));
    end
    bus.branch_valid   = 1'b1;
    bus.branch_address = 11'd2046;
    @(negedge clk);
    check("preload_2046", 32'(bus.cnt), 32'd2046);
    bus.branch_valid = 1'b0;
    @(negedge clk);
    check("count_2047", 32'(bus.cnt), 32'd2047);
    @(negedge clk);
    check("wrap_0", 32'(bus.cnt), 32'd0);

    // 3: branch load, self-branch, branch vs reset
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("cnt_3", 32'(bus.cnt), 32'd3);
    bus.branch_valid   = 1'b1;
    bus.branch_address = 11'h123;
    @(negedge clk);
    check("branch_123", 32'(bus.cnt), 32'h123);
    bus.branch_valid = 1'b0;
    @(negedge clk);
    check("after_branch", 32'(bus.cnt), 32'h124);
    bus.branch_valid   = 1'b1;
    bus.branch_address = 11'h124;
    @(negedge clk);
    check("branch_self", 32'(bus.cnt), 32'h124);
    bus.branch_address = 11'h055;
    resetn = 1'b1;
    @(negedge clk);
    check("reset_over_branch", 32'(bus.cnt), 32'd0);
    bus.branch_valid = 1'b0;

    // 4/5: directed PSR vectors (reset still asserted: flags must not care)
    psr_vecs[0] = '{32'h0000_0000, 1'b1, 5'b10100, "psr_zero_carry"};
    psr_vecs[1] = '{32'h0000_0003, 1'b0, 5'b01000, "psr_pos_even"};
    psr_vecs[2] = '{32'h8000_0000, 1'b0, 5'b00011, "psr_neg_odd"};
    psr_vecs[3] = '{32'h0000_0007, 1'b0, 5'b01001, "psr_pos_odd"};
    psr_vecs[4] = '{32'hFFFF_FFFF, 1'b0, 5'b00010, "psr_all_ones"};
    foreach (psr_vecs[i]) begin
      bus.res   = psr_vecs[i].res;
      bus.carry = psr_vecs[i].carry;
      #1 check(psr_vecs[i].tag, 32'(bus.program_status), 32'(psr_vecs[i].exp));
    end

    // 6a: random PSR vs reference model, plus one-hot P/Z/N
    for (int i = 0; i < 1000; i++) begin
      bus.res   = (i % 10 == 0) ? 32'd0 : $urandom;
      bus.carry = 1'($urandom_range(0, 1));
      #1;
      f = ref_flags(bus.res, bus.carry);
      check("psr_rand", 32'(bus.program_status), 32'(f));
      check("pzn_onehot", 32'($countones(bus.program_status[3:1])), 32'd1);
    end

    // 6b: random branch pattern vs golden PC model
    @(negedge clk);
    resetn = 1'b0;
    exp_pc = 11'd0;
    for (int i = 0; i < 300; i++) begin
      bus.branch_valid   = ($urandom_range(0, 3) == 0);
      bus.branch_address = 11'($urandom);
      if (i % 50 == 7) bus.branch_address = 11'd2047;
      @(negedge clk);
      exp_pc = bus.branch_valid ? bus.branch_address : 11'(exp_pc + 11'd1);
      check("pc_rand", 32'(bus.cnt), 32'(exp_pc));
    end
    bus.branch_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
